// File: rtl/vector_mac_pe.sv
// -----------------------------------------------------------------------------
// vector_mac_pe
// Multi-lane signed multiply-accumulate processing element. LANES-wide
// left/right operand beats are buffered in an input FIFO; the per-beat dot
// product is accumulated over `length` beats and each finished result is
// pushed into an output FIFO behind a valid/ready port.
//
// Optional feature: define PE_SATURATE_EN to clamp every accumulator update
// to the signed ACC_W range and raise the sticky sat_flag. When it is not
// defined, the accumulator wraps modulo 2^ACC_W and sat_flag is tied to 0.
//
// Ports
//   clk, PE_reset_n      clock, asynchronous active-low reset (release is
//                        synchronised internally with two flops)
//   active               1 = compute enabled, 0 = compute frozen
//   clear                synchronous clear of input FIFO and partial sum
//   length               beats per dot product (0 behaves as 1)
//   in_valid/in_ready    input beat handshake (in_ready = input FIFO not full)
//   left_data/right_data lane i at [i*DATA_W +: DATA_W], signed
//   out_valid/out_ready  result handshake (out_valid = output FIFO not empty)
//   out_data             head of output FIFO (0 when empty)
//   comp_count           completed dot products since reset (wraps)
//   busy                 FSM not idle or input FIFO not empty
//   sat_flag             sticky saturation indicator
// -----------------------------------------------------------------------------
module vector_mac_pe #(
   parameter int DATA_W    = 32,
   parameter int ACC_W     = 64,
   parameter int LANES     = 4,
   parameter int IN_DEPTH  = 16,
   parameter int OUT_DEPTH = 4,
   parameter int LEN_W     = 16
) (
   input  logic                      clk,
   input  logic                      PE_reset_n,
   input  logic                      active,
   input  logic                      clear,
   input  logic [LEN_W-1:0]          length,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   left_data,
   input  logic [LANES*DATA_W-1:0]   right_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_W-1:0]          out_data,
   output logic [31:0]               comp_count,
   output logic                      busy,
   output logic                      sat_flag
);

   localparam int IN_AW  = $clog2(IN_DEPTH);
   localparam int OUT_AW = $clog2(OUT_DEPTH);
   localparam int LW     = LANES * DATA_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_STALL = 2'd2
   } state_t;

   // Reset: asynchronous assertion, two-flop synchronised release
   logic [1:0] rst_sync_q;
   logic       rst_n;

   // Reset release synchroniser
   always_ff @(posedge clk or negedge PE_reset_n) begin
      if (!PE_reset_n) rst_sync_q <= 2'b00;
      else             rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   // Storage and state
   logic [LW-1:0]           left_mem_q  [IN_DEPTH];
   logic [LW-1:0]           right_mem_q [IN_DEPTH];
   logic [IN_AW:0]          in_wr_q, in_rd_q;
   logic [ACC_W-1:0]        out_mem_q [OUT_DEPTH];
   logic [OUT_AW:0]         out_wr_q, out_rd_q;
   state_t                  state_q;
   logic [LEN_W-1:0]        len_q, beat_cnt_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [31:0]             comp_count_q;

   // Decode signals
   logic                    in_empty_s, in_full_s, out_empty_s, out_full_s;
   logic [LEN_W-1:0]        len_in_s, len_eff_s;
   logic                    final_s, can_go_s, do_step_s, stall_s;
   logic                    push_in_s, push_out_s, pop_out_s;
   logic [LW-1:0]           left_head_s, right_head_s;
   logic signed [ACC_W-1:0] beat_sum_s, acc_sum_s, acc_upd_s;
`ifdef PE_SATURATE_EN
   logic                    clamp_s;
   logic                    sat_q;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   // FIFO status and step decision
   always_comb begin
      in_empty_s  = (in_wr_q == in_rd_q);
      in_full_s   = (in_wr_q[IN_AW] != in_rd_q[IN_AW]) &&
                    (in_wr_q[IN_AW-1:0] == in_rd_q[IN_AW-1:0]);
      out_empty_s = (out_wr_q == out_rd_q);
      out_full_s  = (out_wr_q[OUT_AW] != out_rd_q[OUT_AW]) &&
                    (out_wr_q[OUT_AW-1:0] == out_rd_q[OUT_AW-1:0]);
      len_in_s    = (length == {LEN_W{1'b0}}) ? {{(LEN_W-1){1'b0}}, 1'b1} : length;
      // In IDLE the product has not started yet, so the live length applies.
      len_eff_s   = (state_q == S_IDLE) ? len_in_s : len_q;
      final_s     = (beat_cnt_q == (len_eff_s - {{(LEN_W-1){1'b0}}, 1'b1}));
      can_go_s    = active && !clear && !in_empty_s;
      // A final beat is only consumed when its result has room to land.
      do_step_s   = can_go_s && !(final_s && out_full_s);
      stall_s     = can_go_s && final_s && out_full_s;
      // Clear wipes the input FIFO, so a beat offered alongside it is dropped.
      push_in_s   = in_valid && !in_full_s && !clear;
      push_out_s  = do_step_s && final_s;
      pop_out_s   = out_ready && !out_empty_s;
      left_head_s  = left_mem_q[in_rd_q[IN_AW-1:0]];
      right_head_s = right_mem_q[in_rd_q[IN_AW-1:0]];
   end

   // Per-beat dot product of the head beat, in ACC_W two's complement
   always_comb begin
      logic signed [DATA_W-1:0] l_lane;
      logic signed [DATA_W-1:0] r_lane;
      beat_sum_s = '0;
      for (int i = 0; i < LANES; i++) begin
         l_lane     = left_head_s[i*DATA_W +: DATA_W];
         r_lane     = right_head_s[i*DATA_W +: DATA_W];
         beat_sum_s = beat_sum_s + (ACC_W'(l_lane) * ACC_W'(r_lane));
      end
   end

   // Accumulator update with optional clamping
   always_comb begin
      acc_sum_s = acc_q + beat_sum_s;
`ifdef PE_SATURATE_EN
      // Overflow only when both addends share a sign that the sum lost.
      clamp_s = (acc_q[ACC_W-1] == beat_sum_s[ACC_W-1]) &&
                (acc_sum_s[ACC_W-1] != acc_q[ACC_W-1]);
      if (clamp_s) acc_upd_s = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
      else         acc_upd_s = acc_sum_s;
`else
      acc_upd_s = acc_sum_s;
`endif
   end

   // Input FIFO operand storage
   always_ff @(posedge clk) begin
      if (push_in_s) begin
         left_mem_q[in_wr_q[IN_AW-1:0]]  <= left_data;
         right_mem_q[in_wr_q[IN_AW-1:0]] <= right_data;
      end
   end

   // Input FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_wr_q <= '0;
         in_rd_q <= '0;
      end else if (clear) begin
         in_wr_q <= '0;
         in_rd_q <= '0;
      end else begin
         if (push_in_s) in_wr_q <= in_wr_q + {{IN_AW{1'b0}}, 1'b1};
         if (do_step_s) in_rd_q <= in_rd_q + {{IN_AW{1'b0}}, 1'b1};
      end
   end

   // Accumulation FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         len_q        <= {{(LEN_W-1){1'b0}}, 1'b1};
         beat_cnt_q   <= '0;
         acc_q        <= '0;
         comp_count_q <= 32'd0;
      end else if (clear) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         acc_q      <= '0;
      end else if (do_step_s) begin
         if (state_q == S_IDLE) len_q <= len_in_s;
         if (final_s) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            acc_q        <= '0;
            comp_count_q <= comp_count_q + 32'd1;
         end else begin
            state_q    <= S_ACCUM;
            beat_cnt_q <= beat_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
            acc_q      <= acc_upd_s;
         end
      end else if (stall_s) begin
         if (state_q == S_IDLE) len_q <= len_in_s;
         state_q <= S_STALL;
      end else begin
         state_q <= state_q;
      end
   end

`ifdef PE_SATURATE_EN
   // Sticky saturation flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               sat_q <= 1'b0;
      else if (!clear && do_step_s && clamp_s) sat_q <= 1'b1;
      else                                      sat_q <= sat_q;
   end
   assign sat_flag = sat_q;
`else
   assign sat_flag = 1'b0;
`endif

   // Output FIFO result storage
   always_ff @(posedge clk) begin
      if (push_out_s) out_mem_q[out_wr_q[OUT_AW-1:0]] <= acc_upd_s;
   end

   // Output FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_wr_q <= '0;
         out_rd_q <= '0;
      end else begin
         if (push_out_s) out_wr_q <= out_wr_q + {{OUT_AW{1'b0}}, 1'b1};
         if (pop_out_s)  out_rd_q <= out_rd_q + {{OUT_AW{1'b0}}, 1'b1};
      end
   end

   assign in_ready   = !in_full_s;
   assign out_valid  = !out_empty_s;
   assign out_data   = out_empty_s ? {ACC_W{1'b0}} : out_mem_q[out_rd_q[OUT_AW-1:0]];
   assign comp_count = comp_count_q;
   assign busy       = (state_q != S_IDLE) || !in_empty_s;

endmodule

// File: tb/tb_vector_mac_pe.sv
module tb_vector_mac_pe;
   localparam int DW = 32;
   localparam int AW = 64;
   localparam int LN = 4;
   localparam int LENW = 16;

   logic            clk = 1'b0;
   logic            PE_reset_n, active, clear, in_valid, in_ready;
   logic [LENW-1:0] length;
   logic [LN*DW-1:0] left_data, right_data;
   logic            out_valid, out_ready, busy, sat_flag;
   logic [AW-1:0]   out_data;
   logic [31:0]     comp_count;

   always #5 clk = ~clk;

   vector_mac_pe dut (
      .clk(clk), .PE_reset_n(PE_reset_n), .active(active), .clear(clear),
      .length(length), .in_valid(in_valid), .in_ready(in_ready),
      .left_data(left_data), .right_data(right_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .comp_count(comp_count),
      .busy(busy), .sat_flag(sat_flag)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d", name, $signed(act), $signed(exp));
      end
   endtask

   // ---------------- reference model ----------------
   longint      exp_q[$];
   longint      mdl_acc = 0;
   int          mdl_cnt = 0;
   int          mdl_len = 1;
   int unsigned mdl_comp = 0;
   bit          mdl_sat = 1'b0;
   bit          model_en = 1'b0;
   int          acc_cnt = 0;

   function automatic longint dot(input logic [LN*DW-1:0] l, input logic [LN*DW-1:0] r);
      longint s = 0;
      int a, b;
      for (int k = 0; k < LN; k++) begin
         a = l[k*DW +: DW];
         b = r[k*DW +: DW];
         s = s + longint'(a) * longint'(b);
      end
      return s;
   endfunction

   function automatic longint madd(input longint a, input longint b);
`ifdef PE_SATURATE_EN
      logic signed [127:0] w;
      longint mx = 64'sh7FFF_FFFF_FFFF_FFFF;
      longint mn = 64'sh8000_0000_0000_0000;
      w = a;
      w = w + b;
      if (w > mx) begin mdl_sat = 1'b1; return mx; end
      if (w < mn) begin mdl_sat = 1'b1; return mn; end
      return a + b;
`else
      return a + b;
`endif
   endfunction

   task automatic model_beat(input logic [LN*DW-1:0] l, input logic [LN*DW-1:0] r);
      if (mdl_cnt == 0) mdl_len = (length == 0) ? 1 : int'(length);
      mdl_acc = madd(mdl_acc, dot(l, r));
      mdl_cnt++;
      if (mdl_cnt == mdl_len) begin
         exp_q.push_back(mdl_acc);
         mdl_acc = 0;
         mdl_cnt = 0;
         mdl_comp++;
      end
   endtask

   // Monitor: sample away from the active edge, feed model, check every pop
   always @(negedge clk) begin
      if (model_en) begin
         if (clear) begin
            mdl_acc = 0;
            mdl_cnt = 0;
         end else if (in_valid && in_ready) begin
            model_beat(left_data, right_data);
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: actual=%0d required=no result", $signed(out_data));
            end else begin
               chk("pop_order", out_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lanes(input int lv, input int rv, input int nl);
      for (int k = 0; k < LN; k++) begin
         left_data[k*DW +: DW]  = (k < nl) ? lv : 0;
         right_data[k*DW +: DW] = (k < nl) ? rv : 0;
      end
   endtask

   task automatic wait_out(input string name, input int bound);
      int n = 0;
      while (!out_valid && n < bound) begin tick(); n++; end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL %s: actual=no out_valid required=out_valid within %0d cycles", name, bound);
      end
   endtask

   task automatic pop_one();
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   typedef struct {
      int     len;
      int     nb;
      int     lv;
      int     rv;
      int     nl;
      longint exp;
   } vec_t;

   vec_t tv[9];

   initial begin
      tv[0] = '{3, 3, 2, 3, 4, 64'sd72};
      tv[1] = '{1, 1, -5, 7, 4, -64'sd140};
      tv[2] = '{0, 1, -5, 7, 4, -64'sd140};
      tv[3] = '{2, 2, 100, -100, 4, -64'sd80000};
      tv[4] = '{5, 5, 1, 1, 4, 64'sd20};
      tv[5] = '{4, 4, -1, -1, 4, 64'sd16};
      tv[6] = '{1, 1, 32767, 32767, 4, 64'sd4294705156};
      tv[7] = '{2, 2, 32'sh8000_0000, 1, 4, -64'sd17179869184};
`ifdef PE_SATURATE_EN
      tv[8] = '{2, 2, 2147483647, 2147483647, 2, 64'sh7FFF_FFFF_FFFF_FFFF};
`else
      tv[8] = '{2, 2, 2147483647, 2147483647, 2, -64'sd17179869180};
`endif

      PE_reset_n = 1'b0; active = 1'b1; clear = 1'b0; length = 16'd1;
      in_valid = 1'b0; out_ready = 1'b0; left_data = '0; right_data = '0;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_comp_count", comp_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat_flag", sat_flag, 0);
      PE_reset_n = 1'b1;
      repeat (4) tick();
      model_en = 1'b1;

      // ---- table-driven products with latency check ----
      for (int v = 0; v < 9; v++) begin
         length = tv[v].len[LENW-1:0];
         set_lanes(tv[v].lv, tv[v].rv, tv[v].nl);
         in_valid = 1'b1;
         repeat (tv[v].nb) tick();
         in_valid = 1'b0;
         chk("lat_early", out_valid, 0);
         tick();
         chk("lat_valid", out_valid, 1);
         chk("tbl_data", out_data, tv[v].exp);
         chk("tbl_count", comp_count, mdl_comp);
         pop_one();
      end
      chk("sat_after_table", sat_flag, mdl_sat);

      // ---- back-to-back length-1 products, no bubble ----
      length = 16'd1;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_lanes(i, 1, 4);
         in_valid = 1'b1;
         tick();
         if (i >= 1) begin
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data", out_data, 64'(4 * (i - 1)));
         end
      end
      in_valid = 1'b0;
      tick();
      chk("b2b_last", out_data, 64'd76);
      tick();
      chk("b2b_empty", out_valid, 0);
      out_ready = 1'b0;

      // ---- input full at 16, output full -> stall, then release ----
      active = 1'b0;
      for (int i = 0; i < 16; i++) begin
         set_lanes(i, 1, 4);
         in_valid = 1'b1;
         tick();
         if (i == 14) chk("in_ready_15", in_ready, 1);
      end
      chk("in_ready_full", in_ready, 0);
      set_lanes(99, 1, 4);
      tick();
      in_valid = 1'b0;
      chk("busy_frozen", busy, 1);
      active = 1'b1;
      repeat (10) tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_head", out_data, 0);
      chk("stall_in_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int n = 0; n < 80 && (out_valid || busy); n++) tick();
      out_ready = 1'b0;
      chk("drain_done", {62'd0, out_valid, busy}, 0);
      chk("drain_count", comp_count, mdl_comp);
      chk("drain_sb", exp_q.size(), 0);

      // ---- clear mid-product ----
      length = 16'd4;
      set_lanes(1, 1, 4);
      in_valid = 1'b1;
      repeat (2) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("pre_clear_busy", busy, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_in_ready", in_ready, 1);
      chk("clear_busy", busy, 0);
      chk("clear_count", comp_count, mdl_comp);
      in_valid = 1'b1;
      repeat (4) tick();
      in_valid = 1'b0;
      wait_out("clear_wait", 20);
      chk("clear_result", out_data, 64'd16);
      pop_one();

      // ---- active=0 freeze mid-product, then length=0 ----
      length = 16'd3;
      set_lanes(-5, 7, 4);
      in_valid = 1'b1;
      tick();
      active = 1'b0;
      repeat (2) tick();
      in_valid = 1'b0;
      repeat (5) tick();
      chk("frozen_valid", out_valid, 0);
      chk("frozen_busy", busy, 1);
      active = 1'b1;
      wait_out("freeze_wait", 20);
      chk("freeze_result", out_data, -64'sd420);
      pop_one();
      length = 16'd0;
      in_valid = 1'b1;
      active = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      chk("len0_frozen", out_valid, 0);
      active = 1'b1;
      wait_out("len0_wait", 20);
      chk("len0_result", out_data, -64'sd140);
      pop_one();

      // ---- randomized batches against the model ----
      for (int b = 0; b < 30; b++) begin
         int lsel, eff, nbeats, start, last, guard;
         lsel = $urandom_range(0, 4);
         eff = (lsel == 0) ? 1 : lsel;
         nbeats = eff * $urandom_range(1, 4);
         length = lsel[LENW-1:0];
         start = acc_cnt; last = acc_cnt; guard = 0;
         in_valid = 1'b0;
         while ((acc_cnt - start) < nbeats && guard < 1000) begin
            active = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid || acc_cnt != last) begin
               last = acc_cnt;
               in_valid = ($urandom_range(0, 3) != 0);
               for (int k = 0; k < LN; k++) begin
                  left_data[k*DW +: DW] = $urandom;
                  right_data[k*DW +: DW] = $urandom;
               end
            end
            tick();
            guard++;
         end
         in_valid = 1'b0;
         active = 1'b1;
         guard = 0;
         while (busy && guard < 300) begin
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            guard++;
         end
         if (busy || (acc_cnt - start) != nbeats) begin
            checks++; errors++;
            $display("FAIL rand_batch: accepted=%0d required=%0d busy=%0d", acc_cnt - start, nbeats, busy);
         end
      end
      out_ready = 1'b1;
      for (int n = 0; n < 40 && out_valid; n++) tick();
      out_ready = 1'b0;
      chk("rand_sb_empty", exp_q.size(), 0);
      chk("rand_count", comp_count, mdl_comp);
      chk("rand_sat", sat_flag, mdl_sat);

      // ---- reset in the middle of operation ----
      length = 16'd1;
      set_lanes(3, 3, 4);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("pre_rst_valid", out_valid, 1);
      active = 1'b0;
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("pre_rst_busy", busy, 1);
      model_en = 1'b0;
      PE_reset_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_count", comp_count, 0);
      chk("mid_rst_sat", sat_flag, 0);
      exp_q.delete();
      tick();
      PE_reset_n = 1'b1;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
